// File: rtl/flm_pkg.sv
// flm_pkg: shared id types, onehot and rotate-priority-encode helpers for the free-list allocator
package flm_pkg;
  localparam int N_DEFAULT = 16;
  localparam int N_MAX = 64;
  localparam int W_MAX = $clog2(N_MAX);
  typedef logic [$clog2(N_DEFAULT)-1:0] id_t;
  typedef logic [N_DEFAULT-1:0] n_t;
  typedef struct packed {
    logic found;
    logic [W_MAX-1:0] idx;
  } pick_t;
  function automatic logic [N_MAX-1:0] onehot(input logic [W_MAX-1:0] id);
    onehot = '0;
    onehot[id] = 1'b1;
  endfunction
  function automatic pick_t rot_pe(input logic [N_MAX-1:0] v, input logic [W_MAX-1:0] ptr, input int n);
    logic [W_MAX-1:0] j;
    rot_pe = '0;
    for (int i = N_MAX - 1; i >= 0; i--) begin
      j = (ptr + W_MAX'(i)) & W_MAX'(n - 1);
      if (i < n && v[j]) rot_pe = '{1'b1, j};
    end
  endfunction
endpackage

// File: rtl/flm_alloc_if.sv
// flm_alloc_if: allocator bus; master drives gnt_vld/gnt_id/alloc_vld/alloc_id/empty_r, slave drives state_i/clear/gnt_rdy
interface flm_alloc_if
  import flm_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  logic [N-1:0] state_i;
  logic clear;
  logic gnt_rdy;
  logic gnt_vld;
  logic [$clog2(N)-1:0] gnt_id;
  logic alloc_vld;
  logic [$clog2(N)-1:0] alloc_id;
  logic empty_r;
  modport master(input state_i, clear, gnt_rdy, output gnt_vld, gnt_id, alloc_vld, alloc_id, empty_r);
  modport slave(output state_i, clear, gnt_rdy, input gnt_vld, gnt_id, alloc_vld, alloc_id, empty_r);
endinterface

// File: rtl/flm_pick.sv
// flm_pick: combinational pick of the first set bit of avail at or above ptr (wrapping) -> found, pick
module flm_pick
  import flm_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0]         avail,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] pick
);
  pick_t p;
  assign p = rot_pe(N_MAX'(avail), W_MAX'(ptr), N);
  assign found = p.found;
  assign pick = $clog2(N)'(p.idx);
endmodule

// File: rtl/flm_alloc.sv
// flm_alloc: pre-stages a free id from tracker state and grants it over valid/ready (ports: clk, rst, bus b)
module flm_alloc
  import flm_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int RR = 0
) (
  input logic      clk,
  input logic      rst,
  flm_alloc_if.master b
);
  localparam int W = $clog2(N);
  logic stg_vld_r, empty_r, stale, gnt_vld, fire, found;
  logic [W-1:0] stg_id_r, ptr_r, pick;
  logic [N-1:0] avail;
  assign stale = stg_vld_r & b.state_i[stg_id_r];
  assign gnt_vld = stg_vld_r & ~b.state_i[stg_id_r];
  assign fire = gnt_vld & b.gnt_rdy & ~b.clear;
  assign avail = ~b.state_i & ~(stg_vld_r ? N'(onehot(W_MAX'(stg_id_r))) : '0);
  flm_pick #(.N(N)) u_pick (
    .avail(avail),
    .ptr  (RR != 0 ? ptr_r : W'(0)),
    .found(found),
    .pick (pick)
  );
  assign b.gnt_vld = gnt_vld;
  assign b.gnt_id = stg_id_r;
  assign b.alloc_vld = fire;
  assign b.alloc_id = stg_id_r;
  assign b.empty_r = empty_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld_r <= 1'b0;
      stg_id_r <= '0;
      ptr_r <= '0;
      empty_r <= 1'b0;
    end else if (b.clear) begin
      stg_vld_r <= 1'b0;
      ptr_r <= '0;
      empty_r <= 1'b0;
    end else begin
      if (!stg_vld_r || fire || stale) begin
        stg_vld_r <= found;
        stg_id_r <= pick;
      end
      if (fire) ptr_r <= stg_id_r + W'(1);
      empty_r <= ~found & ~(stg_vld_r & ~fire);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && b.alloc_vld) assert (!b.state_i[b.alloc_id]);
  end
endmodule

// File: tb/tb_flm_alloc.sv
// tb_flm_alloc: table, hand sequences and random stimulus against a behavioural allocator model for RR=0 and RR=1
module tb_flm_alloc;
  localparam int N = 4;
  typedef struct {
    logic r, rd, c;
    logic [N-1:0] fr, fc;
    logic ev;
    logic [1:0] ei;
    logic ea, ee;
  } vec_t;
  logic clk = 0, rst = 1, rdy = 0, clr = 0;
  logic [N-1:0] frc = '0;
  logic [N-1:0] trk [2];
  int errs = 0, chks = 0;
  bit m_vld [2], m_empty [2];
  int m_id [2], m_ptr [2];
  logic gv [2], av [2], ev [2];
  logic [1:0] gi [2], ai [2];
  logic s_av [2];
  logic [1:0] s_ai [2];
  always #5 clk = ~clk;
  flm_alloc_if #(.N(N)) b0 ();
  flm_alloc_if #(.N(N)) b1 ();
  flm_alloc #(.N(N), .RR(0)) u0 (.clk(clk), .rst(rst), .b(b0));
  flm_alloc #(.N(N), .RR(1)) u1 (.clk(clk), .rst(rst), .b(b1));
  assign b0.state_i = trk[0] | frc;
  assign b1.state_i = trk[1] | frc;
  assign b0.clear = clr;
  assign b1.clear = clr;
  assign b0.gnt_rdy = rdy;
  assign b1.gnt_rdy = rdy;
  assign gv[0] = b0.gnt_vld;
  assign gv[1] = b1.gnt_vld;
  assign av[0] = b0.alloc_vld;
  assign av[1] = b1.alloc_vld;
  assign ev[0] = b0.empty_r;
  assign ev[1] = b1.empty_r;
  assign gi[0] = b0.gnt_id;
  assign gi[1] = b1.gnt_id;
  assign ai[0] = b0.alloc_id;
  assign ai[1] = b1.alloc_id;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    chks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, rd, c, input logic [N-1:0] fr, fc,
                              input logic e_v, input logic [1:0] e_i, input logic e_a, e_e);
    vec_t v;
    v.r = r; v.rd = rd; v.c = c; v.fr = fr; v.fc = fc;
    v.ev = e_v; v.ei = e_i; v.ea = e_a; v.ee = e_e;
    return v;
  endfunction

  // first id that is free in st and not the one already staged, scanning upward from the policy's base
  function automatic void search(input int k, input logic [N-1:0] st, output bit f, output int p);
    int base;
    base = (k == 1) ? m_ptr[k] : 0;
    f = 0;
    p = 0;
    for (int o = 0; o < N; o++) begin
      int j;
      j = (base + o) % N;
      if (!f && !st[j] && !(m_vld[k] && m_id[k] == j)) begin
        f = 1;
        p = j;
      end
    end
  endfunction

  task automatic cyc(input vec_t v, input bit tv);
    bit nv [2], ne [2];
    int ni [2], np [2];
    logic [N-1:0] st;
    bit evld, eal, stl, f;
    int p;
    rst = v.r; rdy = v.rd; clr = v.c; frc = v.fc;
    #4;
    for (int k = 0; k < 2; k++) begin
      st = trk[k] | v.fc;
      evld = m_vld[k] && !st[m_id[k]];
      stl = m_vld[k] && st[m_id[k]];
      eal = evld && v.rd && !v.c;
      chk("gnt_vld", k, int'(gv[k]), int'(evld));
      chk("alloc_vld", k, int'(av[k]), int'(eal));
      chk("empty_r", k, int'(ev[k]), int'(m_empty[k]));
      if (evld) chk("gnt_id", k, int'(gi[k]), m_id[k]);
      if (eal) chk("alloc_id", k, int'(ai[k]), m_id[k]);
      s_av[k] = av[k];
      s_ai[k] = ai[k];
      search(k, st, f, p);
      nv[k] = m_vld[k]; ni[k] = m_id[k]; np[k] = m_ptr[k]; ne[k] = m_empty[k];
      if (v.r || v.c) begin
        nv[k] = 0; np[k] = 0; ne[k] = 0;
        if (v.r) ni[k] = 0;
      end else begin
        if (!m_vld[k] || eal || stl) begin
          nv[k] = f;
          ni[k] = p;
        end
        if (eal) np[k] = (m_id[k] + 1) % N;
        ne[k] = !f && !(m_vld[k] && !eal);
      end
    end
    if (tv) begin
      chk("tab_gnt_vld", 0, int'(gv[0]), int'(v.ev));
      chk("tab_alloc_vld", 0, int'(av[0]), int'(v.ea));
      chk("tab_empty_r", 0, int'(ev[0]), int'(v.ee));
      if (v.ev) chk("tab_gnt_id", 0, int'(gi[0]), int'(v.ei));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = nv[k]; m_id[k] = ni[k]; m_ptr[k] = np[k]; m_empty[k] = ne[k];
      trk[k] = (v.r || v.c) ? '0 : (trk[k] | (s_av[k] ? (N'(1) << s_ai[k]) : '0)) & ~v.fr;
    end
  endtask

  initial begin
    vec_t tab [$];
    int g [$];
    int ex [5] = '{0, 1, 2, 3, 0};
    trk[0] = '0;
    trk[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 0; m_id[k] = 0; m_ptr[k] = 0; m_empty[k] = 0;
    end
    tab.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0, 1, 0, 0, 0, 1, 2'(i), 1, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 0, 4'b0100, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 2, 1, 0));
    tab.push_back(mk(0, 0, 0, 4'b0011, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tab.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 0));
    foreach (tab[i]) cyc(tab[i], 1);
    cyc(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(mk(0, 1, 0, (i == 2) ? 4'b0001 : 4'b0000, 0, 0, 0, 0, 0), 0);
      if (s_av[1]) g.push_back(int'(s_ai[1]));
    end
    chk("rr_grant_count", 1, g.size(), 5);
    for (int i = 0; i < 5; i++) chk("rr_grant_order", 1, (i < g.size()) ? g[i] : -1, ex[i]);
    for (int i = 0; i < 3000; i++) begin
      vec_t rv;
      rv = mk(1'($urandom % 300 == 0), 1'($urandom % 4 != 0), 1'($urandom % 50 == 0),
              N'($urandom & $urandom), ($urandom % 16 == 0) ? N'($urandom) : '0, 0, 0, 0, 0);
      cyc(rv, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
